// File: rtl/lcd_link_pkg.sv
// Shared constants for the LCD serial link arbiter: state encoding,
// default frame geometry and requester indices.
package lcd_link_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    CLEAR    = 3'd1,
    SHIFT_LO = 3'd2,
    SHIFT_HI = 3'd3,
    LOAD     = 3'd4,
    GAP      = 3'd5
  } lcd_state_t;

  localparam int WIDTH_DEF   = 32;
  localparam int CLK_DIV_DEF = 4;

  localparam int REQ0 = 0;
  localparam int REQ1 = 1;

endpackage

// File: rtl/lcd_phase_timer.sv
// Phase timer: down-counter reloaded with CLK_DIV-1 on every phase entry;
// done is high during the final cycle of the phase.
module lcd_phase_timer
  import lcd_link_pkg::*;
#(
  parameter int CLK_DIV = CLK_DIV_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  output logic done
);

  localparam int TW = $clog2(CLK_DIV + 1);

  logic [TW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= TW'(CLK_DIV - 1);
    end else if (cnt != '0) begin
      cnt <= cnt - TW'(1);
    end
  end

  assign done = (cnt == '0);

endmodule

// File: rtl/lcd_link_arbiter.sv
// Round-robin arbiter for two frame sources sharing the serial LCD link.
// Optional clear phase at frame start is built when LCD_ARB_CLEAR_EN is defined.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | link quiet, waiting for a request to arbitrate
// CLEAR    | sclr_n low for one phase (LCD_ARB_CLEAR_EN only)
// SHIFT_LO | sclk low, sdata driving current MSB
// SHIFT_HI | sclk high, sdata held; shift and count bit on exit
// LOAD     | sload high, latches the shifted frame into the LCD
// GAP      | link idle for one phase before the next arbitration
module lcd_link_arbiter
  import lcd_link_pkg::*;
#(
  parameter int WIDTH   = WIDTH_DEF,
  parameter int CLK_DIV = CLK_DIV_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic [WIDTH-1:0] data0,
  output logic             ack0,
  input  logic             req1,
  input  logic [WIDTH-1:0] data1,
  output logic             ack1,
  output logic             busy,
  output logic             sclk,
  output logic             sdata,
  output logic             sload,
  output logic             sclr_n
);

  localparam int BW = $clog2(WIDTH + 1);

  lcd_state_t       state, state_nxt;
  logic [WIDTH-1:0] shreg, shreg_nxt;
  logic [BW-1:0]    bit_cnt, bit_cnt_nxt, bit_cnt_inc;
  logic             last, last_nxt;  // 1: requester 1 was granted last
  logic [1:0]       ack_nxt;
  logic             busy_nxt, sclk_nxt, sdata_nxt, sload_nxt;
  logic             phase_done;

  lcd_phase_timer #(.CLK_DIV(CLK_DIV)) u_phase_timer (
    .clk  (clk),
    .rst  (rst),
    .load (state_nxt != state),
    .done (phase_done)
  );

  always_comb begin
    state_nxt   = state;
    shreg_nxt   = shreg;
    bit_cnt_nxt = bit_cnt;
    last_nxt    = last;
    ack_nxt     = '0;
    bit_cnt_inc = bit_cnt + BW'(1);
    unique case (state)
      IDLE: begin
        if (req0 || req1) begin
          if (req1 && (!req0 || !last)) begin
            ack_nxt[REQ1] = 1'b1;
            shreg_nxt     = data1;
            last_nxt      = 1'b1;
          end else begin
            ack_nxt[REQ0] = 1'b1;
            shreg_nxt     = data0;
            last_nxt      = 1'b0;
          end
          bit_cnt_nxt = '0;
`ifdef LCD_ARB_CLEAR_EN
          state_nxt = CLEAR;
`else
          state_nxt = SHIFT_LO;
`endif
        end
      end
`ifdef LCD_ARB_CLEAR_EN
      CLEAR:    if (phase_done) state_nxt = SHIFT_LO;
`endif
      SHIFT_LO: if (phase_done) state_nxt = SHIFT_HI;
      SHIFT_HI: begin
        if (phase_done) begin
          shreg_nxt   = shreg << 1;
          bit_cnt_nxt = bit_cnt_inc;
          state_nxt   = (bit_cnt_inc == BW'(WIDTH)) ? LOAD : SHIFT_LO;
        end
      end
      LOAD:     if (phase_done) state_nxt = GAP;
      GAP:      if (phase_done) state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase

    // Link outputs are decoded from next-state so they land in flops.
    busy_nxt  = (state_nxt != IDLE);
    sclk_nxt  = (state_nxt == SHIFT_HI);
    sdata_nxt = ((state_nxt == SHIFT_LO) || (state_nxt == SHIFT_HI)) && shreg_nxt[WIDTH-1];
    sload_nxt = (state_nxt == LOAD);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      shreg   <= '0;
      bit_cnt <= '0;
      last    <= 1'b1;
      ack0    <= 1'b0;
      ack1    <= 1'b0;
      busy    <= 1'b0;
      sclk    <= 1'b0;
      sdata   <= 1'b0;
      sload   <= 1'b0;
    end else begin
      state   <= state_nxt;
      shreg   <= shreg_nxt;
      bit_cnt <= bit_cnt_nxt;
      last    <= last_nxt;
      ack0    <= ack_nxt[REQ0];
      ack1    <= ack_nxt[REQ1];
      busy    <= busy_nxt;
      sclk    <= sclk_nxt;
      sdata   <= sdata_nxt;
      sload   <= sload_nxt;
    end
  end

`ifdef LCD_ARB_CLEAR_EN
  always_ff @(posedge clk) begin
    if (rst) sclr_n <= 1'b1;
    else     sclr_n <= (state_nxt != CLEAR);
  end
`else
  assign sclr_n = 1'b1;
`endif

endmodule

// File: tb/tb_lcd_link_arbiter.sv
// Scoreboard bench for lcd_link_arbiter: a transaction-level arbitration model
// predicts grant order and frame contents; a monitor checks the link waveform.
module tb_lcd_link_arbiter;

  localparam int W = 8;
  localparam int D = 2;
`ifdef LCD_ARB_CLEAR_EN
  localparam int C = D;
`else
  localparam int C = 0;
`endif
  localparam int SLOAD_OFF = C + 2 * W * D;
  localparam int BUSY_OFF  = SLOAD_OFF + 2 * D;
  localparam int FRAME     = BUSY_OFF + 1;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         req0 = 1'b0, req1 = 1'b0;
  logic [W-1:0] data0 = '0, data1 = '0;
  logic         ack0, ack1, busy, sclk, sdata, sload, sclr_n;

  lcd_link_arbiter #(.WIDTH(W), .CLK_DIV(D)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .data0(data0), .ack0(ack0),
    .req1(req1), .data1(data1), .ack1(ack1),
    .busy(busy), .sclk(sclk), .sdata(sdata), .sload(sload), .sclr_n(sclr_n)
  );

  always #5 clk = ~clk;

  typedef struct {
    int           who;
    logic [W-1:0] data;
    int           gap;   // required ack-to-ack spacing, -1 if unconstrained
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc   = 0;
  int   m_last = 1;   // model round-robin pointer: requester granted last

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endfunction

  // Monitor
  logic         rst_at_edge = 1'b0;
  bit           cur_valid = 0;
  exp_t         cur;
  logic [W-1:0] bits;
  int           nbits, ack_cyc, last_ack = -1000, first_rise, sload_len, clr_cnt;
  logic         sclk_p = 0, sload_p = 0, busy_p = 0, sdata_p = 0;

  always @(posedge clk) rst_at_edge <= rst;

  always @(negedge clk) begin
    cyc++;
    if (rst_at_edge) begin
      chk("reset_outputs", {ack0, ack1, busy, sclk, sdata, sload, sclr_n}, 7'b0000001);
      cur_valid = 0;
    end else begin
      if (ack0 || ack1) begin
        chk("single_ack", {ack0, ack1} == 2'b11, 0);
        if (exp_q.size() == 0) begin
          chk("unexpected_ack", {ack0, ack1}, 0);
        end else begin
          cur = exp_q.pop_front();
          chk("grant_who", {ack1, ack0}, (cur.who == 1) ? 2'b10 : 2'b01);
          if (cur.gap > 0) chk("ack_spacing", cyc - last_ack, cur.gap);
          last_ack   = cyc;
          ack_cyc    = cyc;
          cur_valid  = 1;
          bits       = '0;
          nbits      = 0;
          first_rise = -1;
          sload_len  = 0;
          clr_cnt    = 0;
        end
      end
      if (cur_valid) begin
        if (sclk && !sclk_p) begin
          bits = {bits[W-2:0], sdata};
          nbits++;
          if (first_rise < 0) first_rise = cyc - ack_cyc;
        end
        if (sclk) chk("sdata_stable", sdata, sdata_p);
        if (!sclr_n) begin
          if (clr_cnt == 0) chk("clr_start", cyc - ack_cyc, 0);
          clr_cnt++;
        end
        if (sload) begin
          if (!sload_p) begin
            chk("sload_offset", cyc - ack_cyc, SLOAD_OFF);
            chk("frame_data", bits, cur.data);
            chk("bit_count", nbits, W);
            chk("clr_len", clr_cnt, C);
          end
          chk("load_link_idle", {sclk, sdata}, 2'b00);
          sload_len++;
        end
        if (!sload && sload_p) chk("sload_len", sload_len, D);
        if (!busy && busy_p) begin
          chk("busy_drop", cyc - ack_cyc, BUSY_OFF);
          chk("first_sclk", first_rise, C + D);
          cur_valid = 0;
        end
      end else begin
        chk("idle_sload", sload, 0);
      end
    end
    sclk_p  = sclk;
    sload_p = sload;
    busy_p  = busy;
    sdata_p = sdata;
  end

  task automatic wait_idle();
    int t = 0;
    while (busy !== 1'b0 && t < 300) begin
      @(negedge clk);
      t++;
    end
    chk("idle_wait", busy, 0);
    repeat ($urandom_range(0, 2)) @(negedge clk);
  endtask

  // Issue one or two requests; dly1>0 raises req1 that many cycles later.
  task automatic issue(input bit en0, input bit en1, input int dly1,
                       input logic [W-1:0] d0, input logic [W-1:0] d1);
    bit got0, got1;
    int t, w;
    exp_t e;
    if (en0 && en1 && dly1 == 0) begin
      w = (m_last == 1) ? 0 : 1;
      e.who = w;     e.data = (w == 1) ? d1 : d0; e.gap = -1;    exp_q.push_back(e);
      e.who = 1 - w; e.data = (w == 1) ? d0 : d1; e.gap = FRAME; exp_q.push_back(e);
      m_last = 1 - w;
    end else begin
      if (en0) begin e.who = 0; e.data = d0; e.gap = -1; exp_q.push_back(e); m_last = 0; end
      if (en1) begin e.who = 1; e.data = d1; e.gap = en0 ? FRAME : -1; exp_q.push_back(e); m_last = 1; end
    end
    data0 = d0;
    data1 = d1;
    got0 = !en0;
    got1 = !en1;
    req0 = en0;
    req1 = en1 && (dly1 == 0);
    t = 0;
    while (!(got0 && got1) && t < 300) begin
      @(negedge clk);
      t++;
      if (t == 1) chk("ack_latency", ack0 | ack1, 1);
      if (ack0) begin req0 = 0; got0 = 1; end
      if (ack1) begin req1 = 0; got1 = 1; end
      if (en1 && dly1 > 0 && t == dly1) req1 = 1;
    end
    chk("ack_wait", {got0, got1}, 2'b11);
    req0 = 0;
    req1 = 0;
    wait_idle();
  endtask

  task automatic reset_mid_shift();
    exp_t e;
    int t = 0, n = 0;
    logic sp = 0;
    e.who = 0; e.data = 8'hFF; e.gap = -1; exp_q.push_back(e);
    m_last = 0;
    data0 = 8'hFF;
    req0 = 1;
    while (n < 3 && t < 300) begin
      @(negedge clk);
      t++;
      if (ack0) req0 = 0;
      if (sclk && !sp) n++;
      sp = sclk;
    end
    chk("rise_wait", n, 3);
    req0 = 0;
    rst = 1;
    @(negedge clk);
    rst = 0;
    m_last = 1;
  endtask

  initial begin
    exp_t e;
    int mode;
    // Reset held 3 cycles with req0 already up; ack follows release by one cycle.
    data0 = 8'h3C;
    req0  = 1;
    e.who = 0; e.data = 8'h3C; e.gap = -1; exp_q.push_back(e);
    repeat (3) @(negedge clk);
    rst = 0;
    @(negedge clk);
    chk("ack_after_reset", ack0, 1);
    req0 = 0;
    m_last = 0;
    wait_idle();

    issue(1, 0, 0, 8'hA5, 8'h00);
    issue(1, 1, 0, 8'h81, 8'h7E);
    issue(1, 1, 0, 8'hC3, 8'h5A);
    issue(1, 1, 9, 8'h12, 8'hE7);
    reset_mid_shift();
    issue(1, 0, 0, 8'h0F, 8'h00);

    for (int i = 0; i < 24; i++) begin
      mode = $urandom_range(0, 3);
      case (mode)
        0: issue(1, 0, 0, W'($urandom), W'($urandom));
        1: issue(0, 1, 0, W'($urandom), W'($urandom));
        2: issue(1, 1, 0, W'($urandom), W'($urandom));
        default: issue(1, 1, $urandom_range(3, 30), W'($urandom), W'($urandom));
      endcase
    end

    repeat (5) @(negedge clk);
    chk("queue_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

endmodule
